// File: rtl/game_stats_if.sv
// Bundle between the round/score core and its consumers: event and control
// levels in, score/time/lives/state out.
interface game_stats_if #(
  parameter int SCORE_W = 14,
  parameter int TIME_W  = 9,
  parameter int LIVES_W = 2
);
  logic               start;
  logic               pause;
  logic               coin_det_in;
  logic               outbounds;
  logic               game_win;
  logic [SCORE_W-1:0] score;
  logic [TIME_W-1:0]  g_time;
  logic [LIVES_W-1:0] lives;
  logic [SCORE_W-1:0] high_score;
  logic [2:0]         state;
  logic               game_over;
  logic               game_won;

  modport master (
    output start, pause, coin_det_in, outbounds, game_win,
    input  score, g_time, lives, high_score, state, game_over, game_won
  );

  modport slave (
    input  start, pause, coin_det_in, outbounds, game_win,
    output score, g_time, lives, high_score, state, game_over, game_won
  );
endinterface

// File: rtl/game_stats_core.sv
// Round state machine with edge-detected collision events, saturating score,
// prescaled countdown timer, lives and a high score retained across rounds.
module game_stats_core #(
  parameter int SCORE_W      = 14,
  parameter int TIME_W       = 9,
  parameter int LIVES_W      = 2,
  parameter int START_TIME   = 500,
  parameter int START_LIVES  = 3,
  parameter int COIN_PTS     = 10,
  parameter int WIN_BONUS    = 500,
  parameter int TIME_MULT    = 2,
  parameter int TICK_DIV     = 67108864,
  parameter int RESPAWN_CYC  = 1024,
  parameter bit ZERO_ON_LOSS = 1'b1
) (
  input logic        clk,
  input logic        rst,
  game_stats_if.slave bus
);

  localparam int SUM_W = SCORE_W + TIME_W + 4;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RSP_W = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;

  localparam logic [SUM_W-1:0]   SCORE_MAX = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [RSP_W-1:0]   RSP_LAST  = RSP_W'(RESPAWN_CYC - 1);
  localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(START_TIME);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

  typedef enum logic [2:0] {
    ST_READY   = 3'd0,
    ST_PLAY    = 3'd1,
    ST_RESPAWN = 3'd2,
    ST_WON     = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [TIME_W-1:0]  g_time_q, g_time_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [RSP_W-1:0]   rsp_q, rsp_d;
  logic [3:0]         prev_q;

  logic [3:0]         in_now, ev;
  logic               start_ev, coin_ev, out_ev, win_ev;
  logic               running, tick, time_out;
  logic [TIME_W-1:0]  time_dec;
  logic [SUM_W-1:0]   add_w, sum_w;
  logic [SCORE_W-1:0] score_sat;

  assign in_now   = {bus.game_win, bus.outbounds, bus.coin_det_in, bus.start};
  assign ev       = in_now & ~prev_q;
  assign start_ev = ev[0];
  assign coin_ev  = ev[1];
  assign out_ev   = ev[2];
  assign win_ev   = ev[3];

  // Game time only advances while the character is in the world and unpaused.
  assign running  = ((state_q == ST_PLAY) || (state_q == ST_RESPAWN)) && !bus.pause;
  assign tick     = running && (pre_q == PRE_LAST);
  assign time_dec = (tick && (g_time_q != '0)) ? g_time_q - TIME_W'(1) : g_time_q;
  assign time_out = tick && (time_dec == '0);

  // Credit is summed wide so a win with a large remaining time cannot wrap.
  always_comb begin
    add_w = '0;
    if (coin_ev) add_w = add_w + SUM_W'(COIN_PTS);
    if (win_ev)  add_w = add_w + SUM_W'(WIN_BONUS) + SUM_W'(TIME_MULT) * SUM_W'(g_time_q);
    sum_w     = SUM_W'(score_q) + add_w;
    score_sat = (sum_w > SCORE_MAX) ? {SCORE_W{1'b1}} : sum_w[SCORE_W-1:0];
  end

  // NOTE: every next-state signal gets its hold value first so no path
  // through the case statement leaves one unassigned (which would infer a latch).
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    high_d   = high_q;
    g_time_d = g_time_q;
    lives_d  = lives_q;
    pre_d    = pre_q;
    rsp_d    = rsp_q;

    if (running) pre_d = tick ? '0 : pre_q + PRE_W'(1);

    unique case (state_q)
      ST_READY, ST_WON, ST_OVER: begin
        if (start_ev) begin
          state_d  = ST_PLAY;
          score_d  = '0;
          g_time_d = TIME_INIT;
          lives_d  = LIVES_INIT;
          pre_d    = '0;
        end
      end
      ST_PLAY: begin
        g_time_d = time_dec;
        score_d  = score_sat;
        if (win_ev) begin
          state_d = ST_WON;
        end else if (out_ev) begin
          lives_d = (lives_q != '0) ? lives_q - LIVES_W'(1) : lives_q;
          if (lives_d == '0 || time_out) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_RESPAWN;
            rsp_d   = '0;
          end
        end else if (time_out) begin
          state_d = ST_OVER;
        end
      end
      ST_RESPAWN: begin
        g_time_d = time_dec;
        rsp_d    = rsp_q + RSP_W'(1);
        if (time_out)              state_d = ST_OVER;
        else if (rsp_q == RSP_LAST) state_d = ST_PLAY;
      end
      default: state_d = ST_READY;
    endcase

    // A loss of the last life wipes the score before it can reach the high score.
    if (ZERO_ON_LOSS && (state_d == ST_OVER) && (state_q != ST_OVER) && (lives_d == '0))
      score_d = '0;

    if ((state_d != state_q) && ((state_d == ST_WON) || (state_d == ST_OVER)) &&
        (score_d > high_q))
      high_d = score_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_READY;
      score_q  <= '0;
      high_q   <= '0;
      g_time_q <= TIME_INIT;
      lives_q  <= LIVES_INIT;
      pre_q    <= '0;
      rsp_q    <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      high_q   <= high_d;
      g_time_q <= g_time_d;
      lives_q  <= lives_d;
      pre_q    <= pre_d;
      rsp_q    <= rsp_d;
      prev_q   <= in_now;
    end
  end

  assign bus.score      = score_q;
  assign bus.high_score = high_q;
  assign bus.g_time     = g_time_q;
  assign bus.lives      = lives_q;
  assign bus.state      = state_q;
  assign bus.game_over  = (state_q == ST_OVER);
  assign bus.game_won   = (state_q == ST_WON);

endmodule

// File: tb/tb_game_stats_core.sv
// Directed bench: three parameterisations share one input stream; each phase
// resets all of them and checks the instance the phase targets.
module tb_game_stats_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  game_stats_if #(.SCORE_W(14), .TIME_W(9), .LIVES_W(2)) a_if ();
  game_stats_if #(.SCORE_W(14), .TIME_W(9), .LIVES_W(2)) b_if ();
  game_stats_if #(.SCORE_W(10), .TIME_W(9), .LIVES_W(2)) c_if ();

  game_stats_core #(
    .SCORE_W(14), .TIME_W(9), .LIVES_W(2), .START_TIME(5), .START_LIVES(3),
    .TICK_DIV(4), .RESPAWN_CYC(8)
  ) dut_a (.clk(clk), .rst(rst), .bus(a_if));

  game_stats_core #(
    .SCORE_W(14), .TIME_W(9), .LIVES_W(2), .START_TIME(40), .START_LIVES(3),
    .TICK_DIV(4), .RESPAWN_CYC(8)
  ) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  game_stats_core #(
    .SCORE_W(10), .TIME_W(9), .LIVES_W(2), .START_TIME(200), .START_LIVES(3),
    .TICK_DIV(4), .RESPAWN_CYC(8)
  ) dut_c (.clk(clk), .rst(rst), .bus(c_if));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic pa, input logic co, input logic ob, input logic gw);
    a_if.start = st; a_if.pause = pa; a_if.coin_det_in = co; a_if.outbounds = ob; a_if.game_win = gw;
    b_if.start = st; b_if.pause = pa; b_if.coin_det_in = co; b_if.outbounds = ob; b_if.game_win = gw;
    c_if.start = st; c_if.pause = pa; c_if.coin_det_in = co; c_if.outbounds = ob; c_if.game_win = gw;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    #12;
    check("a_rst_score", a_if.score, 0);
    check("a_rst_time", a_if.g_time, 5);
    check("a_rst_lives", a_if.lives, 3);
    check("a_rst_state", a_if.state, 0);
    check("a_rst_high", a_if.high_score, 0);
    step(1);
    rst = 1'b1;

    // Time-out round with no events
    drive(1, 0, 0, 0, 0);
    step(1);
    check("a_play_entry", a_if.state, 1);
    step(4);
    check("a_time_after_4", a_if.g_time, 4);
    step(15);
    check("a_time_after_19", a_if.g_time, 1);
    check("a_state_after_19", a_if.state, 1);
    step(1);
    check("a_timeout_time", a_if.g_time, 0);
    check("a_timeout_state", a_if.state, 4);
    check("a_timeout_score", a_if.score, 0);
    check("a_timeout_lives", a_if.lives, 3);
    check("a_timeout_over", a_if.game_over, 1);

    // New round, paused: held coin credited once
    drive(0, 1, 0, 0, 0);
    step(1);
    drive(1, 1, 0, 0, 0);
    step(1);
    check("a_round2_state", a_if.state, 1);
    check("a_round2_time", a_if.g_time, 5);
    drive(1, 1, 1, 0, 0);
    step(1);
    check("a_coin_first", a_if.score, 10);
    step(49);
    check("a_coin_held", a_if.score, 10);
    drive(1, 1, 0, 0, 0);
    step(1);
    drive(1, 1, 1, 0, 0);
    step(1);
    check("a_coin_second", a_if.score, 20);
    check("a_paused_time", a_if.g_time, 5);

    // Lives lost, respawn grace ignores outbounds
    drive(1, 1, 0, 1, 0);
    step(1);
    check("a_life1_lives", a_if.lives, 2);
    check("a_life1_state", a_if.state, 2);
    drive(1, 1, 0, 0, 0);
    step(1);
    drive(1, 1, 0, 1, 0);
    step(1);
    check("a_respawn_ignore", a_if.lives, 2);
    drive(1, 1, 0, 0, 0);
    step(5);
    check("a_respawn_hold", a_if.state, 2);
    step(1);
    check("a_respawn_done", a_if.state, 1);
    drive(1, 1, 0, 1, 0);
    step(1);
    check("a_life2_lives", a_if.lives, 1);
    drive(1, 1, 0, 0, 0);
    step(8);
    check("a_respawn2_done", a_if.state, 1);
    drive(1, 1, 0, 1, 0);
    step(1);
    check("a_life3_lives", a_if.lives, 0);
    check("a_life3_state", a_if.state, 4);
    check("a_loss_score_cleared", a_if.score, 0);
    check("a_loss_high", a_if.high_score, 0);
    drive(0, 1, 0, 0, 0);

    // Win with coin in the same cycle
    rst = 1'b0;
    #1;
    check("b_rst_time", b_if.g_time, 40);
    step(1);
    rst = 1'b1;
    drive(1, 1, 0, 0, 0);
    step(1);
    check("b_play_entry", b_if.state, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1, 0, 0);
      step(1);
      drive(1, 1, 0, 0, 0);
      step(1);
    end
    check("b_score_100", b_if.score, 100);
    check("b_time_40", b_if.g_time, 40);
    drive(1, 1, 1, 0, 1);
    step(1);
    check("b_win_score", b_if.score, 690);
    check("b_win_state", b_if.state, 3);
    check("b_win_high", b_if.high_score, 690);
    check("b_win_flag", b_if.game_won, 1);

    // Next round times out below the high score
    drive(0, 1, 0, 0, 0);
    step(1);
    drive(1, 1, 0, 0, 0);
    step(1);
    check("b_round2_score", b_if.score, 0);
    check("b_round2_high", b_if.high_score, 690);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0);
      step(1);
      drive(1, 1, 0, 0, 0);
      step(1);
    end
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 300 && b_if.state != 3'd4; i++) step(1);
    check("b_timeout_state", b_if.state, 4);
    check("b_timeout_score", b_if.score, 30);
    check("b_timeout_high", b_if.high_score, 690);
    check("b_timeout_time", b_if.g_time, 0);

    // Asynchronous reset mid-round
    drive(0, 0, 0, 0, 0);
    step(1);
    drive(1, 0, 0, 0, 0);
    step(1);
    drive(1, 0, 1, 0, 0);
    step(1);
    check("b_mid_score", b_if.score, 10);
    drive(0, 1, 0, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    check("b_async_score", b_if.score, 0);
    check("b_async_high", b_if.high_score, 0);
    check("b_async_state", b_if.state, 0);
    check("b_async_time", b_if.g_time, 40);
    check("b_async_lives", b_if.lives, 3);

    // Saturation on a narrow score
    step(1);
    rst = 1'b1;
    drive(1, 1, 0, 0, 0);
    step(1);
    for (int i = 0; i < 100; i++) begin
      drive(1, 1, 1, 0, 0);
      step(1);
      drive(1, 1, 0, 0, 0);
      step(1);
    end
    check("c_score_1000", c_if.score, 1000);
    check("c_time_200", c_if.g_time, 200);
    drive(1, 1, 0, 0, 1);
    step(1);
    check("c_sat_score", c_if.score, 1023);
    check("c_sat_state", c_if.state, 3);
    check("c_sat_high", c_if.high_score, 1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
